// File: rtl/pemstat_pkg.sv
// Shared types and widths for the statistics-counter read/load controller.
package pemstat_pkg;

    localparam int CNT_W   = 31;
    localparam int RDATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

endpackage

// File: rtl/pemstat_rdmux.sv
// Registered NUM_CNT:1 selection of counter value and overflow flag.
// OVF_EN (set by the top from PEMSTAT_RDCTL_OVF_EN) gates the overflow bit.
module pemstat_rdmux
    import pemstat_pkg::*;
#(
    parameter int NUM_CNT = 32,
    parameter int AW      = 5,
    parameter bit OVF_EN  = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cap_en,
    input  logic                     force_zero,
    input  logic [AW-1:0]            sel,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_val,
    input  logic [NUM_CNT-1:0]       cnt_ovf,
    output logic [CNT_W-1:0]         val_q,
    output logic                     ovf_q
);

    logic [CNT_W-1:0] val_sel;
    logic             ovf_sel;

    // Select the addressed counter; an index beyond NUM_CNT matches nothing and yields 0.
    always_comb begin
        val_sel = '0;
        ovf_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (sel == AW'(i)) begin
                val_sel = cnt_val[i*CNT_W +: CNT_W];
                ovf_sel = cnt_ovf[i];
            end
        end
    end

    // Capture on the edge that ends ACCESS, the same edge at which the counter clears.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val_q <= '0;
            ovf_q <= 1'b0;
        end else if (cap_en) begin
            if (force_zero) begin
                val_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                val_q <= val_sel;
                ovf_q <= OVF_EN & ovf_sel;
            end
        end
    end

endmodule

// File: rtl/pemstat_rdctl.sv
// Host read/load controller for a bank of statistics counters.
// Optional feature macro: PEMSTAT_RDCTL_OVF_EN (overflow flag in rdata[31] plus ovf_clr strobes).
module pemstat_rdctl
    import pemstat_pkg::*;
#(
    parameter int NUM_CNT = 32,
    parameter int AW      = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req,
    input  logic                     wr,
    input  logic [AW-1:0]            addr,
    input  logic [CNT_W-1:0]         wdata,
    input  logic                     clr_on_rd,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_val,
    input  logic [NUM_CNT-1:0]       cnt_ovf,
    output logic                     ack,
    output logic [RDATA_W-1:0]       rdata,
    output logic [NUM_CNT-1:0]       cnt_clr,
    output logic [NUM_CNT-1:0]       ovf_clr,
    output logic [NUM_CNT-1:0]       cnt_ld,
    output logic [CNT_W-1:0]         ld_data
);

`ifdef PEMSTAT_RDCTL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [AW-1:0]      addr_q;
    logic               wr_q;
    logic [CNT_W-1:0]   wdata_q;
    logic               clr_q;
    logic [NUM_CNT-1:0] sel_hot;
    logic [CNT_W-1:0]   val_q;
    logic               ovf_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are sampled only on the accepting edge out of IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            clr_q   <= 1'b0;
        end else if (state_q == IDLE && req) begin
            addr_q  <= addr;
            wr_q    <= wr;
            wdata_q <= wdata;
            clr_q   <= clr_on_rd;
        end
    end

    // One-hot decode of the registered address; out-of-range addresses decode to zero.
    always_comb begin
        sel_hot = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (addr_q == AW'(i)) begin
                sel_hot[i] = 1'b1;
            end
        end
    end

    // Next state and strobes; strobes derive from state so reset drops them at once.
    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        cnt_clr = '0;
        ovf_clr = '0;
        cnt_ld  = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = ACK;
                if (wr_q) begin
                    cnt_ld = sel_hot;
                end else begin
                    if (clr_q) begin
                        cnt_clr = sel_hot;
                    end
                    if (OVF_EN) begin
                        ovf_clr = sel_hot;
                    end
                end
            end
            ACK: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ld_data = wdata_q;
    assign rdata   = {ovf_q, val_q};

    pemstat_rdmux #(
        .NUM_CNT (NUM_CNT),
        .AW      (AW),
        .OVF_EN  (OVF_EN)
    ) u_rdmux (
        .clk        (clk),
        .reset_n    (reset_n),
        .cap_en     (state_q == ACCESS),
        .force_zero (wr_q),
        .sel        (addr_q),
        .cnt_val    (cnt_val),
        .cnt_ovf    (cnt_ovf),
        .val_q      (val_q),
        .ovf_q      (ovf_q)
    );

endmodule

// File: doc/pemstat_rdctl.md
PEMSTAT_RDCTL -- requirements
Module: pemstat_rdctl

Interface
REQ-001 SHALL have parameter NUM_CNT, default 32, meaning number of attached statistics counters (2..64).
REQ-002 SHALL have parameter AW, default 5, meaning host address width; AW >= clog2(NUM_CNT).
REQ-003 SHALL have port clk  in  1  meaning single clock for all logic.
REQ-004 SHALL have port reset_n  in  1  meaning reset; synchronous and active-low.
REQ-005 SHALL have port req  in  1  meaning host access request, level, held until ack.
REQ-006 SHALL have port wr  in  1  meaning 1 = load counter, 0 = read counter; sampled with req.
REQ-007 SHALL have port addr  in  AW  meaning counter index.
REQ-008 SHALL have port wdata  in  31  meaning load value.
REQ-009 SHALL have port clr_on_rd  in  1  meaning enable clear-on-read.
REQ-010 SHALL have port cnt_val  in  NUM_CNT*31  meaning flattened counter values, counter i at [31i+30:31i].
REQ-011 SHALL have port cnt_ovf  in  NUM_CNT  meaning per-counter overflow flags.
REQ-012 SHALL have port ack  out  1  meaning one-cycle access completion pulse.
REQ-013 SHALL have port rdata  out  32  meaning read result, valid while ack=1.
REQ-014 SHALL have port cnt_clr  out  NUM_CNT  meaning one-hot counter clear strobe.
REQ-015 SHALL have port ovf_clr  out  NUM_CNT  meaning one-hot overflow-flag clear strobe.
REQ-016 SHALL have port cnt_ld  out  NUM_CNT  meaning one-hot counter load strobe.
REQ-017 SHALL have port ld_data  out  31  meaning load value for cnt_ld.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, ACK; IDLE->ACCESS on req=1; ACCESS->ACK unconditionally; ACK->IDLE unconditionally.
REQ-019 SHALL register addr, wr, wdata and clr_on_rd at the accepting edge E0; it SHALL NOT sample them in other states.
REQ-020 Read: cnt_clr[addr] (if clr_on_rd) and ovf_clr[addr] SHALL be high exactly in the cycle between E0 and E1; rdata[30:0] SHALL capture cnt_val[addr] at E1, the same edge at which the counter clears, so no increment is lost.
REQ-021 Write: cnt_ld[addr] SHALL be high exactly in the cycle between E0 and E1, with ld_data = registered wdata; cnt_clr and ovf_clr SHALL stay 0.
REQ-022 ack SHALL be high exactly in the cycle between E1 and E2; fixed latency is 2 cycles from acceptance to ack.
REQ-023 rdata SHALL hold its value until the next read capture; after a write it SHALL read 0 during ack.
REQ-024 addr >= NUM_CNT SHALL complete normally with rdata = 0 and no strobes.
REQ-025 If req is still high in the IDLE cycle after ack, it SHALL be accepted as a new access; the host deasserts req in the ack cycle.
REQ-026 All strobes SHALL be one-hot or zero, and SHALL never be asserted outside ACCESS.

Reset
REQ-027 reset_n=0 at a clk edge SHALL force IDLE, ack=0, rdata=0, cnt_clr=0, ovf_clr=0, cnt_ld=0 and ld_data=0.
REQ-028 Reset during ACCESS SHALL drop all strobes at that edge; no ack SHALL follow.

Configuration
REQ-029 With `PEMSTAT_RDCTL_OVF_EN` defined, rdata[31] SHALL capture cnt_ovf[addr] at E1 and ovf_clr SHALL be driven per REQ-020.
REQ-030 Without `PEMSTAT_RDCTL_OVF_EN`, rdata[31] SHALL be 0 and ovf_clr SHALL be constant 0.

Structure
REQ-031 Package pemstat_pkg SHALL hold the FSM state enum, CNT_W=31 and RDATA_W=32.
REQ-032 Sub-module pemstat_rdmux SHALL contain the registered NUM_CNT:1 value/overflow selection; all else SHALL be flat.

Verification
REQ-033 Read addr=3 with cnt_val[3]=0x1234 and clr_on_rd=1 -> ack 2 cycles after acceptance, rdata=0x00001234, and cnt_clr=0x8 for one cycle.
REQ-034 Read with clr_on_rd=0 -> cnt_clr stays 0 and the counter value is unchanged on a repeat read.
REQ-035 Write addr=7, wdata=0x3FFFF -> cnt_ld=0x80 for one cycle with ld_data=0x3FFFF, then ack with rdata=0.
REQ-036 OVF_EN defined, cnt_ovf[2]=1, read addr=2 -> rdata[31]=1 and ovf_clr=0x4 for one cycle; with OVF_EN undefined -> rdata[31]=0.
REQ-037 addr=40 with NUM_CNT=32 -> ack with rdata=0 and all strobes 0.
REQ-038 reset_n=0 in the ACCESS cycle -> strobes 0 at the next edge, no ack, FSM in IDLE.
